// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, even parity, stop.
// A one-entry holding register lets the next byte queue behind the frame on the line.
module uart_tx #(
  parameter int FREQUENCY = 50_000_000,
  parameter int BAUD      = 9600
) (
  input  logic       clk_rx,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int          CLKS_PER_BIT = FREQUENCY / BAUD;
  localparam logic [17:0] BIT_LAST     = 18'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [17:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic        out_q, out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic        bit_end;
  logic        load;
  logic        accept;

  assign bit_end = (baud_q == BIT_LAST);
  assign accept  = tx_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    baud_d      = bit_end ? 18'd0 : baud_q + 18'd1;
    bit_d       = bit_q;
    out_d       = out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ready_d     = ready_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    load        = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = 18'd0;
        out_d  = 1'b1;
        load   = hold_full_q;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          out_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_PARITY;
            out_d   = parity_q;
          end else begin
            out_d = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          out_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        out_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Held byte enters the shifter; from STOP this chains frames with no idle gap.
    if (load) begin
      shift_d     = hold_q;
      parity_d    = ^hold_q;
      hold_full_d = 1'b0;
      baud_d      = 18'd0;
      state_d     = S_START;
      out_d       = 1'b0;
      busy_d      = 1'b1;
    end

    // ready re-opens one edge after the holding register drains.
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
      ready_d     = 1'b0;
    end else if (!hold_full_q) begin
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk_rx) begin
    if (rst) begin
      state_q     <= S_IDLE;
      baud_q      <= 18'd0;
      bit_q       <= 3'd0;
      out_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_ff @(posedge clk_rx) begin
    hold_q   <= hold_d;
    shift_q  <= shift_d;
    parity_q <= parity_d;
  end

  assign tx_ready = ready_q;
  assign tx_out   = out_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-timeline reference model checked every cycle,
// plus table-driven frames and hand-written back-to-back / reset sequences.
module tb_uart_tx;

  localparam int CPB   = 10;
  localparam int FRAME = 11 * CPB;

  logic       clk_rx = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  int vectors;
  int miscompares;

  uart_tx #(.FREQUENCY(96000), .BAUD(9600)) dut (
    .clk_rx  (clk_rx),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_out  (tx_out),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk_rx = ~clk_rx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9) return ^b;
    return 1'b1;
  endfunction

  // Reference model: a frame occupies FRAME cycles from the edge it starts on;
  // a held byte starts on the first edge the line is free; ready reopens the
  // edge after the held byte leaves.
  bit         m_ok = 1'b0;
  bit         m_active, m_held, m_ready, m_hb, m_acc;
  logic [7:0] m_cur, m_hbyte;
  int         m_t = 0;
  int         m_start;
  logic       m_out, m_busy, m_done;

  initial begin
    forever begin
      @(negedge clk_rx);
      if (m_ok) begin
        chk("model_line", tx_out, m_out);
        chk("model_ready", tx_ready, m_ready);
        chk("model_busy", tx_busy, m_busy);
        chk("model_done", tx_done, m_done);
      end
      m_t++;
      if (rst === 1'b1) begin
        m_active = 0; m_held = 0; m_ready = 1;
        m_out = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_ok = 1'b1;
      end else if (m_ok) begin
        m_done = m_active && (m_t == m_start + FRAME);
        if (m_done) m_active = 0;
        m_hb = m_held;
        if (m_held && !m_active) begin
          m_active = 1; m_start = m_t; m_cur = m_hbyte; m_held = 0;
        end
        m_acc   = (tx_valid === 1'b1) && m_ready;
        m_ready = m_acc ? 1'b0 : !m_hb;
        if (m_acc) begin
          m_held = 1; m_hbyte = tx_data;
        end
        m_busy = m_active;
        m_out  = m_active ? frame_bit(m_cur, (m_t - m_start) / CPB) : 1'b1;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_rx);
    while (!(tx_busy === 1'b0 && tx_ready === 1'b1) && n < 2000) begin
      @(negedge clk_rx);
      n++;
    end
    if (n >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: busy=%b ready=%b required busy=0 ready=1", tx_busy, tx_ready);
    end
  endtask

  task automatic put_byte(input logic [7:0] d);
    @(posedge clk_rx); #1;
    tx_valid = 1'b1; tx_data = d;
    @(posedge clk_rx); #1;
    tx_valid = 1'b0; tx_data = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [10:0] f, input string nm);
    put_byte(d);
    @(negedge clk_rx);
    chk({nm, "_latency"}, tx_out, 1'b1);
    chk({nm, "_ready_low"}, tx_ready, 1'b0);
    @(negedge clk_rx);
    chk({nm, "_start"}, tx_out, 1'b0);
    chk({nm, "_busy"}, tx_busy, 1'b1);
    for (int k = 0; k < 11; k++) begin
      repeat (k == 0 ? 5 : 10) @(negedge clk_rx);
      chk($sformatf("%s_bit%0d", nm, k), tx_out, f[k]);
    end
    repeat (4) @(negedge clk_rx);
    chk({nm, "_done_early"}, tx_done, 1'b0);
    chk({nm, "_busy_end"}, tx_busy, 1'b1);
    @(negedge clk_rx);
    chk({nm, "_done"}, tx_done, 1'b1);
    chk({nm, "_busy_clr"}, tx_busy, 1'b0);
    @(negedge clk_rx);
    chk({nm, "_done_pulse"}, tx_done, 1'b0);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
    string       name;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int t, d1, d2, ndone, rises;
    logic prev_r;
    vectors = 0; miscompares = 0;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;

    // Frame bit k at index k: start, d0..d7, parity, stop.
    tbl[0] = '{8'hA5, 11'b101_0100_1010, "a5"};
    tbl[1] = '{8'h01, 11'b110_0000_0010, "01"};
    tbl[2] = '{8'h3C, 11'b100_0111_1000, "3c"};
    tbl[3] = '{8'hFF, 11'b101_1111_1110, "ff"};
    tbl[4] = '{8'h00, 11'b100_0000_0000, "00"};
    tbl[5] = '{8'h80, 11'b111_0000_0000, "80"};

    repeat (3) @(posedge clk_rx);
    #1 rst = 1'b0;
    @(negedge clk_rx);
    chk("rst_out", tx_out, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);

    for (int i = 0; i < 6; i++) begin
      wait_idle();
      send_frame(tbl[i].data, tbl[i].frame, tbl[i].name);
    end

    // Back-to-back: 0xFF queued during the 0x3C frame
    wait_idle();
    put_byte(8'h3C);
    repeat (30) @(posedge clk_rx);
    put_byte(8'hFF);
    d1 = -1; d2 = -1; ndone = 0; rises = 0;
    @(negedge clk_rx);
    prev_r = tx_ready;
    for (t = 0; t < 300; t++) begin
      @(negedge clk_rx);
      if (prev_r === 1'b0 && tx_ready === 1'b1) rises++;
      prev_r = tx_ready;
      if (tx_done === 1'b1) begin
        ndone++;
        if (d1 < 0) begin
          d1 = t;
          chk("b2b_no_gap", tx_out, 1'b0);
          chk("b2b_busy_held", tx_busy, 1'b1);
        end else begin
          d2 = t;
        end
      end
    end
    chk("b2b_done_count", ndone, 2);
    chk("b2b_done_spacing", d2 - d1, FRAME);
    chk("b2b_ready_rises", rises, 1);

    // Backpressure: valid held high with data changing every cycle
    wait_idle();
    @(posedge clk_rx); #1;
    tx_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tx_data = 8'($urandom);
      @(posedge clk_rx); #1;
    end
    tx_valid = 1'b0;

    // Randomized traffic
    wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_rx); #1;
      tx_valid = ($urandom % 8) == 0;
      tx_data  = 8'($urandom);
    end
    tx_valid = 1'b0;

    // Reset mid-frame with a byte held: both bytes are dropped
    wait_idle();
    put_byte(8'h5A);
    repeat (20) @(posedge clk_rx);
    put_byte(8'hC3);
    repeat (15) @(posedge clk_rx);
    #1 rst = 1'b1;
    @(posedge clk_rx); #1 rst = 1'b0;
    @(negedge clk_rx);
    chk("midrst_out", tx_out, 1'b1);
    chk("midrst_ready", tx_ready, 1'b1);
    chk("midrst_busy", tx_busy, 1'b0);
    chk("midrst_done", tx_done, 1'b0);
    repeat (300) @(negedge clk_rx);
    chk("postrst_out", tx_out, 1'b1);
    chk("postrst_busy", tx_busy, 1'b0);

    // Idle line
    repeat (500) @(negedge clk_rx);
    chk("idle_out", tx_out, 1'b1);
    chk("idle_busy", tx_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
